// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters (round-robin).
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority over requester 1.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             grant0, grant1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
`else
            // On a tie the requester that was not served last wins.
            grant0 = req0_valid && (!req1_valid || last_q);
            grant1 = req1_valid && (!req0_valid || !last_q);
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        owner_d      = owner_q;
        last_d       = last_q;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    alu_a_d  = grant1 ? req1_a  : req0_a;
                    alu_b_d  = grant1 ? req1_b  : req0_b;
                    alu_op_d = grant1 ? req1_op : req0_op;
                    owner_d  = grant1;
                    state_d  = StExec;
                end
            end
            StExec: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp0_valid_d = !owner_q;
                rsp1_valid_d = owner_q;
                state_d      = StResp;
            end
            StResp: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    last_d       = owner_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic against a transaction-level model. Honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;
    localparam int W  = 32;
    localparam int OW = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [OW-1:0] req0_op = '0, req1_op = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [W-1:0]  rsp_result, alu_a, alu_b, alu_result;
    logic          rsp_zero, alu_zero, busy;
    logic [OW-1:0] alu_op;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    // Stand-in for the external combinational ALU.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [OW-1:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);
    assign alu_zero   = (alu_result == '0);

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: at most one operation outstanding, visible two cycles after accept.
    bit           m_pend;
    bit           m_owner;
    bit           m_last;
    int           m_acc;
    int           cyc = 0;
    logic [W-1:0] m_a, m_b;
    logic [OW-1:0] m_op;
    bit           order[$];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        reset  = 1'b0;
        m_pend = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic run(input int ncyc, input int pv, input int pr);
        bit g0_prev = 1'b0, g1_prev = 1'b0;
        bit e_g0, e_g1, e_rv;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            // Requesters hold valid and operands until accepted.
            if (!req0_valid || g0_prev) begin
                req0_valid = ($urandom_range(99) < pv);
                req0_a = $urandom; req0_b = $urandom; req0_op = OW'($urandom_range(15));
            end
            if (!req1_valid || g1_prev) begin
                req1_valid = ($urandom_range(99) < pv);
                req1_a = $urandom; req1_b = $urandom; req1_op = OW'($urandom_range(15));
            end
            if ($urandom_range(3) == 0) begin
                req0_b = req0_a; req1_b = req1_a;
            end
            rsp0_ready = ($urandom_range(99) < pr);
            rsp1_ready = ($urandom_range(99) < pr);
            #1;
            e_g0 = !m_pend && req0_valid && (!req1_valid || FIXED || m_last);
            e_g1 = !m_pend && req1_valid && !e_g0;
            e_rv = m_pend && (cyc >= m_acc + 2);
            chk("r_req0_ready", req0_ready, e_g0);
            chk("r_req1_ready", req1_ready, e_g1);
            chk("r_busy", busy, m_pend);
            chk("r_rsp0_valid", rsp0_valid, e_rv && !m_owner);
            chk("r_rsp1_valid", rsp1_valid, e_rv && m_owner);
            if (m_pend && cyc == m_acc + 1) begin
                chk("r_alu_a", alu_a, m_a);
                chk("r_alu_b", alu_b, m_b);
                chk("r_alu_op", alu_op, m_op);
            end
            if (e_rv) begin
                chk("r_result", rsp_result, alu_fn(m_a, m_b, m_op));
                chk("r_zero", rsp_zero, alu_fn(m_a, m_b, m_op) == '0);
            end
            if (req0_ready || req1_ready) order.push_back(req1_ready);
            if (e_rv && (m_owner ? rsp1_ready : rsp0_ready)) begin
                m_pend = 1'b0;
                m_last = m_owner;
            end else if (e_g0 || e_g1) begin
                m_pend  = 1'b1;
                m_owner = e_g1;
                m_acc   = cyc;
                m_a  = e_g1 ? req1_a  : req0_a;
                m_b  = e_g1 ? req1_b  : req0_b;
                m_op = e_g1 ? req1_op : req0_op;
            end
            g0_prev = req0_valid && req0_ready;
            g1_prev = req1_valid && req1_ready;
            cyc++;
        end
    endtask

    typedef struct {
        bit            req;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [OW-1:0] op;
        logic [W-1:0]  res;
        bit            zero;
    } vec_t;

    task automatic single_op(input vec_t v);
        @(negedge clk);
        if (v.req) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
        end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("t_ready", v.req ? req1_ready : req0_ready, 1);
        chk("t_other_ready", v.req ? req0_ready : req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("t_alu_a", alu_a, v.a);
        chk("t_alu_b", alu_b, v.b);
        chk("t_alu_op", alu_op, v.op);
        chk("t_exec_busy", busy, 1);
        chk("t_exec_rsp", {rsp1_valid, rsp0_valid}, 0);
        @(negedge clk);
        #1;
        chk("t_rsp_valid", {rsp1_valid, rsp0_valid}, v.req ? 2'b10 : 2'b01);
        chk("t_result", rsp_result, v.res);
        chk("t_zero", rsp_zero, v.zero);
        @(negedge clk);
        #1;
        chk("t_done_busy", busy, 0);
        chk("t_done_rsp", {rsp1_valid, rsp0_valid}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[6];
        logic [W-1:0]  sa, sb;
        logic [OW-1:0] sop;
        logic [3:0]    exp_order;

        tbl[0] = '{1'b0, 32'd5,          32'd3,          4'b0010, 32'd8,          1'b0};
        tbl[1] = '{1'b1, 32'd7,          32'd7,          4'b0110, 32'd0,          1'b1};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          1'b1};
        tbl[3] = '{1'b1, 32'hF0F0_0000,  32'h0F0F_FFFF,  4'b0001, 32'hFFFF_FFFF,  1'b0};
        tbl[4] = '{1'b0, 32'd3,          32'd5,          4'b0111, 32'd1,          1'b0};
        tbl[5] = '{1'b1, 32'h0000_AAAA,  32'h0000_5555,  4'b0000, 32'd0,          1'b1};

        do_reset();
        for (int i = 0; i < 6; i++) single_op(tbl[i]);

        // Idle: ALU outputs hold their last value.
        sa = alu_a; sb = alu_b; sop = alu_op;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_ready", {req1_ready, req0_ready}, 0);
            chk("idle_alu_a", alu_a, sa);
            chk("idle_alu_b", alu_b, sb);
            chk("idle_alu_op", alu_op, sop);
        end

        // Response backpressure with req1 waiting.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23; req0_op = 4'b0010;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1 chk("bp_accept", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_op = 4'b0110;
        #1 chk("bp_exec_req1_ready", req1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp1_valid", rsp1_valid, 0);
            chk("bp_result", rsp_result, 32'd123);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_busy", busy, 1);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_rel_busy", busy, 0);
        chk("bp_rel_rsp0", rsp0_valid, 0);
        chk("bp_rel_req1_ready", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0; rsp1_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_req1_rsp", {rsp1_valid, rsp0_valid}, 2'b10);
        chk("bp_req1_result", rsp_result, 32'd5);

        // Reset while in EXEC drops the transaction.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd77; req0_b = 32'd11; req0_op = 4'b0010;
        rsp0_ready = 1'b1;
        #1 chk("rx_accept", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0; reset = 1'b1;
        #1 chk("rx_exec_alu_a", alu_a, 32'd77);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rx_alu_a", alu_a, 0);
        chk("rx_alu_b", alu_b, 0);
        chk("rx_alu_op", alu_op, 0);
        chk("rx_busy", busy, 0);
        chk("rx_rsp", {rsp1_valid, rsp0_valid}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("rx_no_rsp", {rsp1_valid, rsp0_valid}, 0);
        end
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 chk("rx_first_grant", {req1_ready, req0_ready}, 2'b01);

        // Contention: both valid continuously.
        do_reset();
        order.delete();
        run(12, 100, 100);
        exp_order = FIXED ? 4'b0000 : 4'b1010;
        chk("cont_count", (order.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) chk("cont_order", order[i], exp_order[i]);
        end

        // Randomized traffic with random response backpressure.
        do_reset();
        run(1500, 60, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
